// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans a double-buffered 4-digit BCD value onto a common-select seven-segment display.
// Optional per-digit blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES   = 25,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 1
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 25
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
`ifdef SEG7_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic        frame_tick
);

    localparam int                TICK_W     = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);
    // XOR masks that turn the internal active-high levels into pin levels
    localparam logic [6:0]        SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_POL     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]        SEL_POL    = (SEL_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [TICK_W-1:0] tick_cnt_r;
    logic [1:0]        dig_idx_r;
    logic              boundary_s;

    logic [15:0]       pending_val_r;
    logic [3:0]        pending_dp_r;
    logic [15:0]       shadow_val_r;
    logic [3:0]        shadow_dp_r;

    logic [3:0]        cur_nib_s;
    logic              lz_blank_s;
    logic [6:0]        seg_on_s;
    logic              dp_on_s;
    logic [3:0]        sel_on_s;

    // Segment pattern (g..a) for one nibble; non-decimal codes show a dash.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            default: pat = 7'b1000000;
        endcase
        return pat;
    endfunction

    assign boundary_s = (tick_cnt_r == TICK_LAST) && (dig_idx_r == 2'd3);

    // Slot tick counter and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
            dig_idx_r  <= 2'd0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
            dig_idx_r  <= dig_idx_r + 2'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Pending/shadow double buffer; a load on the boundary cycle bypasses straight to shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_val_r <= 16'h0000;
            pending_dp_r  <= 4'h0;
            shadow_val_r  <= 16'h0000;
            shadow_dp_r   <= 4'h0;
        end else begin
            if (load) begin
                pending_val_r <= value;
                pending_dp_r  <= dp_mask;
            end
            if (boundary_s) begin
                shadow_val_r <= load ? value   : pending_val_r;
                shadow_dp_r  <= load ? dp_mask : pending_dp_r;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int                 FRM_W    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [3:0]       pending_bm_r;
    logic [3:0]       shadow_bm_r;
    logic [FRM_W-1:0] frame_cnt_r;
    logic             blink_phase_r;

    // Blink mask double buffer, same capture rules as dp_mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_bm_r <= 4'h0;
            shadow_bm_r  <= 4'h0;
        end else begin
            if (load) begin
                pending_bm_r <= blink_mask;
            end
            if (boundary_s) begin
                shadow_bm_r <= load ? blink_mask : pending_bm_r;
            end
        end
    end

    // Frame counter; blink_phase flips every BLINK_FRAMES frames and starts visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (boundary_s) begin
            if (frame_cnt_r == FRM_LAST) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + FRM_W'(1);
            end
        end
    end
`endif

    // Next output levels (active-high) from the current slot and shadow contents.
    always_comb begin
        cur_nib_s  = 4'h0;
        lz_blank_s = 1'b0;
        seg_on_s   = 7'h00;
        dp_on_s    = 1'b0;
        sel_on_s   = 4'h0;
        case (dig_idx_r)
            2'd0: begin
                cur_nib_s  = shadow_val_r[3:0];
                lz_blank_s = 1'b0;
            end
            2'd1: begin
                cur_nib_s  = shadow_val_r[7:4];
                lz_blank_s = (shadow_val_r[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nib_s  = shadow_val_r[11:8];
                lz_blank_s = (shadow_val_r[15:8] == 8'h00);
            end
            2'd3: begin
                cur_nib_s  = shadow_val_r[15:12];
                lz_blank_s = (shadow_val_r[15:12] == 4'h0);
            end
            default: begin
                cur_nib_s  = 4'h0;
                lz_blank_s = 1'b0;
            end
        endcase
        if (tick_cnt_r < TICK_BLANK) begin
            sel_on_s = 4'h0;
        end else begin
            sel_on_s = 4'b0001 << dig_idx_r;
            if (blank_lz && lz_blank_s) begin
                seg_on_s = 7'h00;
            end else begin
                seg_on_s = seg7_decode(cur_nib_s);
            end
            dp_on_s = shadow_dp_r[dig_idx_r];
`ifdef SEG7_BLINK_EN
            if (!blink_phase_r && shadow_bm_r[dig_idx_r]) begin
                seg_on_s = 7'h00;
                dp_on_s  = 1'b0;
            end else begin
                dp_on_s  = shadow_dp_r[dig_idx_r];
            end
`endif
        end
    end

    // Output registers with polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_POL;
            dp         <= DP_POL;
            digit_sel  <= SEL_POL;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_on_s ^ SEG_POL;
            dp         <= dp_on_s ^ DP_POL;
            digit_sel  <= sel_on_s ^ SEL_POL;
            frame_tick <= boundary_s;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the calculator datapath.
- Takes a 4-digit packed BCD value (16 bits) from the control FSM and time-multiplexes it onto the shared 4-digit common-select seven-segment display.
- Includes a built-in segment decoder, leading-zero blanking, per-digit decimal points and inter-digit blanking (anti-ghosting).
- The displayed value is double-buffered, so an update never tears mid-frame.

Parameters:
- DIGIT_CYCLES, 25, clk cycles per digit slot (≥2). 10 kHz clock gives a 100 Hz frame rate.
- BLANK_CYCLES, 2, leading cycles of each slot with all digit selects inactive (< DIGIT_CYCLES).
- SEG_ACTIVE_LOW, 0, when 1, seg and dp are driven inverted.
- SEL_ACTIVE_LOW, 1, when 1, digit_sel is driven inverted.

Ports:
- clk  in  1  system clock (internal LF oscillator domain)
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; capture value and dp_mask
- value  in  16  packed BCD, [3:0]=digit0 (rightmost) … [15:12]=digit3
- dp_mask  in  4  decimal point enable per digit, bit i = digit i
- blank_lz  in  1  level; enables leading-zero blanking
- seg  out  7  segments, seg[0]=a … seg[6]=g
- dp  out  1  decimal point segment
- digit_sel  out  4  one-hot digit enable, bit i = digit i
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - tick_cnt = 0, dig_idx = 0.
  - pending and shadow registers (value + dp_mask) = 0.
  - frame_tick = 0.
  - seg, dp and digit_sel all at their inactive level (off after the polarity parameters are applied).
  - Reset asserted mid-frame aborts the scan immediately. The first slot after release is digit 0, starting with its blank interval.
- Counters:
  - tick_cnt counts 0 … DIGIT_CYCLES-1.
  - On wrap, dig_idx increments 0→1→2→3→0.
  - A frame boundary is the cycle where tick_cnt wraps with dig_idx = 3.
- Load handshake:
  - load=1 writes value and dp_mask into pending. There is no busy/ack; load is accepted every cycle.
  - At each frame boundary, shadow ← pending.
  - If load coincides with the boundary, shadow takes the value/dp_mask inputs directly (bypass), and pending is also written.
  - Back-to-back loads within one frame: last one wins.
- frame_tick: registered, high for exactly the one cycle after the boundary (the same cycle the new shadow becomes visible).
- Output timing: all outputs are registered; they reflect (tick_cnt, dig_idx, shadow) of the previous cycle.
  - Blank interval (tick_cnt < BLANK_CYCLES): digit_sel all inactive; seg and dp inactive.
  - Otherwise: digit_sel one-hot at dig_idx; seg = decode(shadow nibble[dig_idx]); dp = dp_mask[dig_idx].
- Decoder, segments in g…a order:
  - 0=0111111
  - 1=0000110
  - 2=1011011
  - 3=1001111
  - 4=1100110
  - 5=1101101
  - 6=1111101
  - 7=0000111
  - 8=1111111
  - 9=1101111
  - Nibbles A–F display a dash (g only, 1000000).
- Leading-zero blanking (blank_lz=1):
  - Digit i (i = 3, 2, 1) has seg forced off when nibble i and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - Non-BCD nibbles count as non-zero.
  - dp is unaffected by blanking.
  - blank_lz is sampled live each cycle; it is not buffered.
- Polarity: SEG_ACTIVE_LOW and SEL_ACTIVE_LOW invert only at the output registers. Internal logic is always active-high.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- When defined:
  - Adds input blink_mask [3:0] (captured with load, double-buffered like dp_mask).
  - Adds parameter BLINK_FRAMES, default 25.
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase resets to 1 (visible).
  - While blink_phase=0, digits with blink_mask bit set have seg and dp forced off; digit_sel timing is unchanged.
- When undefined: the blink_mask port and blink logic are absent, and all digits are always visible.

Test Plan:
- Reset, then observe with DIGIT_CYCLES=4, BLANK_CYCLES=1, SEL_ACTIVE_LOW=0 → all outputs off.
  - Per slot: 1 blank cycle, then 3 cycles of digit_sel=0001, 0010, 0100, 1000 in order.
  - frame_tick every 16 cycles.
- load value=16'h1234, dp_mask=4'b0100 mid-frame → old value (0000) finishes the current frame.
  - Next frame shows digit0 seg=1100110 (4), digit2 seg=1011011 (2) with dp=1.
  - Displayed change coincides with the frame_tick cycle.
- value=16'h0070, blank_lz=1 → digits 3 and 2 seg=0, digit1=0000111, digit0=0111111.
  - With blank_lz=0, digits 3 and 2 show 0111111.
- value=16'h00A5 → digit1 shows 1000000 (dash); with blank_lz=1, digits 3 and 2 are blanked and digit1 is not blanked.
- load asserted exactly on the boundary cycle with 16'h9999 → the following frame shows 9999 (bypass). Assert reset mid-slot → outputs inactive the next cycle; scan restarts at digit 0.
- SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 → digit0 visible 2 frames, dark 2 frames, repeating; other digits always visible.
